// File: rtl/nmos_phase_pkg.sv
// Shared types and helpers for the NMOS two-phase clock sequencer.
// Build option NMOS_PHASE_STEP_EN (see nmos_phase_seq) adds single-cycle stepping.
package nmos_phase_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        G1   = 3'd2,
        P2   = 3'd3,
        G2   = 3'd4
    } phase_state_e;

    // Timer must hold the largest reload value, max(DIV, GAP, 1) - 1, with headroom.
    function automatic int timer_w(input int div, input int gap);
        int m;
        m = (div > gap) ? div : gap;
        m = (m < 1) ? 1 : m;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/nmos_phase_timer.sv
// Loadable down-counter that times the phase and gap intervals.
// expire is high while the count sits at zero.
module nmos_phase_timer #(
    parameter int W = 2
) (
    input  logic         main_clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count_r;

    // Reload on request, otherwise count down and hold at zero.
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {W{1'b0}}) begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = (count_r == {W{1'b0}});

endmodule

// File: rtl/nmos_phase_seq.sv
// Two-phase non-overlapping clock sequencer driving C1/C2/R into an NMOS netlist.
// Define NMOS_PHASE_STEP_EN to let a rising step edge launch one cycle from IDLE.
module nmos_phase_seq
    import nmos_phase_pkg::*;
#(
    parameter int DIV     = 2,
    parameter int GAP     = 1,
    parameter int RST_CYC = 2,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             main_clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    output logic             C1,
    output logic             C2,
    output logic             R,
    output logic             cyc_strb,
    output logic [CNT_W-1:0] cyc_cnt
);

    localparam int TW  = timer_w(DIV, GAP);
    localparam int RCW = $clog2(RST_CYC + 2);
    localparam logic [TW-1:0]  DIV_LD = TW'(DIV - 1);
    localparam logic [TW-1:0]  GAP_LD = TW'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [RCW-1:0] RST_LD = RCW'(RST_CYC);
    localparam logic           R_INIT = (RST_CYC != 0) ? 1'b1 : 1'b0;

    phase_state_e     state_r;
    phase_state_e     state_next_s;
    logic             tmr_load_s;
    logic [TW-1:0]    tmr_val_s;
    logic             tmr_exp_s;
    logic             p2_exit_s;
    logic             launch_s;
    logic             c1_r;
    logic             c2_r;
    logic             r_r;
    logic             strb_r;
    logic [CNT_W-1:0] cnt_r;
    logic [RCW-1:0]   rst_cnt_r;

`ifdef NMOS_PHASE_STEP_EN
    logic step_q_r;
    logic step_q2_r;

    // Register step twice so a launch needs a clean low-to-high transition.
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q_r  <= 1'b0;
            step_q2_r <= 1'b0;
        end else begin
            step_q_r  <= step;
            step_q2_r <= step_q_r;
        end
    end

    // Only consulted in IDLE, so edges arriving mid-cycle are simply lost.
    assign launch_s = run | (step_q_r & ~step_q2_r);
`else
    logic unused_step_s;
    assign unused_step_s = step;
    assign launch_s      = run;
`endif

    nmos_phase_timer #(
        .W (TW)
    ) u_timer (
        .main_clk (main_clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .expire   (tmr_exp_s)
    );

    // Next-state decode; the timer is reloaded on every phase transition.
    always_comb begin
        state_next_s = state_r;
        tmr_load_s   = 1'b0;
        tmr_val_s    = DIV_LD;
        p2_exit_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (launch_s) begin
                    state_next_s = P1;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = DIV_LD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            P1: begin
                if (tmr_exp_s) begin
                    tmr_load_s = 1'b1;
                    if (GAP > 0) begin
                        state_next_s = G1;
                        tmr_val_s    = GAP_LD;
                    end else begin
                        state_next_s = P2;
                        tmr_val_s    = DIV_LD;
                    end
                end else begin
                    state_next_s = P1;
                end
            end
            G1: begin
                if (tmr_exp_s) begin
                    state_next_s = P2;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = DIV_LD;
                end else begin
                    state_next_s = G1;
                end
            end
            P2: begin
                if (tmr_exp_s) begin
                    p2_exit_s = 1'b1;
                    if (GAP > 0) begin
                        state_next_s = G2;
                        tmr_load_s   = 1'b1;
                        tmr_val_s    = GAP_LD;
                    end else if (run) begin
                        state_next_s = P1;
                        tmr_load_s   = 1'b1;
                        tmr_val_s    = DIV_LD;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = P2;
                end
            end
            G2: begin
                if (tmr_exp_s) begin
                    if (run) begin
                        state_next_s = P1;
                        tmr_load_s   = 1'b1;
                        tmr_val_s    = DIV_LD;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = G2;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register; enables decode the next state so they switch on entry/exit edges.
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            c1_r    <= 1'b0;
            c2_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            c1_r    <= (state_next_s == P1);
            c2_r    <= (state_next_s == P2);
        end
    end

    // Cell reset countdown; R only moves on a P2 exit so the final P2 sees a stable R.
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_cnt_r <= RST_LD;
            r_r       <= R_INIT;
        end else if (p2_exit_s && (rst_cnt_r != {RCW{1'b0}})) begin
            rst_cnt_r <= rst_cnt_r - {{(RCW-1){1'b0}}, 1'b1};
            r_r       <= (rst_cnt_r == {{(RCW-1){1'b0}}, 1'b1}) ? 1'b0 : r_r;
        end else begin
            rst_cnt_r <= rst_cnt_r;
            r_r       <= r_r;
        end
    end

    // Completed-cycle strobe and counter; counting starts only once R was already low.
    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_r <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            strb_r <= p2_exit_s;
            if (p2_exit_s && !r_r) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign C1       = c1_r;
    assign C2       = c2_r;
    assign R        = r_r;
    assign cyc_strb = strb_r;
    assign cyc_cnt  = cnt_r;

endmodule

// File: tb/tb_nmos_phase_seq.sv
// Scoreboard bench: a position-in-period model predicts every cycle of two sequencer
// configurations (DIV=2/GAP=1/RST_CYC=2 and DIV=1/GAP=0/RST_CYC=1, both CNT_W=4).
module tb_nmos_phase_seq;

    logic       main_clk = 1'b0;
    logic       rst_n    = 1'b1;
    logic       run      = 1'b0;
    logic       step     = 1'b0;
    logic       a_c1, a_c2, a_r, a_strb;
    logic [3:0] a_cnt;
    logic       b_c1, b_c2, b_r, b_strb;
    logic [3:0] b_cnt;

    nmos_phase_seq #(.DIV(2), .GAP(1), .RST_CYC(2), .CNT_W(4)) dut_a (
        .main_clk (main_clk), .rst_n (rst_n), .run (run), .step (step),
        .C1 (a_c1), .C2 (a_c2), .R (a_r), .cyc_strb (a_strb), .cyc_cnt (a_cnt)
    );

    nmos_phase_seq #(.DIV(1), .GAP(0), .RST_CYC(1), .CNT_W(4)) dut_b (
        .main_clk (main_clk), .rst_n (rst_n), .run (run), .step (step),
        .C1 (b_c1), .C2 (b_c2), .R (b_r), .cyc_strb (b_strb), .cyc_cnt (b_cnt)
    );

    always #5 main_clk = ~main_clk;

`ifdef NMOS_PHASE_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit [7:0] q_a[$];
    bit [7:0] q_b[$];

    int p_div[2] = '{2, 1};
    int p_gap[2] = '{1, 0};
    int p_rst[2] = '{2, 1};
    int m_pos[2];
    int m_rc[2];
    int m_cnt[2];
    bit m_r[2];
    bit m_s1, m_s2;

    function automatic void model_reset(int k);
        m_pos[k] = -1;
        m_rc[k]  = p_rst[k];
        m_r[k]   = (p_rst[k] != 0);
        m_cnt[k] = 0;
    endfunction

    // One clock edge of the reference: position within the 2*DIV+2*GAP period, -1 = idle.
    function automatic bit [7:0] model_edge(int k, bit run_v, bit rise);
        int div = p_div[k];
        int gap = p_gap[k];
        int per = 2 * div + 2 * gap;
        int ex  = 2 * div + gap - 1;
        bit strb, c1, c2;
        strb = (m_pos[k] == ex);
        if (strb) begin
            if (!m_r[k]) m_cnt[k] = (m_cnt[k] + 1) % 16;
            if (m_rc[k] > 0) begin
                m_rc[k] = m_rc[k] - 1;
                if (m_rc[k] == 0) m_r[k] = 1'b0;
            end
        end
        if (m_pos[k] < 0) m_pos[k] = (run_v || (STEP_EN && rise)) ? 0 : -1;
        else if (m_pos[k] == per - 1) m_pos[k] = run_v ? 0 : -1;
        else m_pos[k] = m_pos[k] + 1;
        c1 = (m_pos[k] >= 0) && (m_pos[k] < div);
        c2 = (m_pos[k] >= div + gap) && (m_pos[k] < 2 * div + gap);
        return {c1, c2, m_r[k], strb, 4'(m_cnt[k])};
    endfunction

    // Reference model: predicts outputs after each edge and queues them.
    initial forever begin
        bit rise;
        @(posedge main_clk or negedge rst_n);
        if (!rst_n) begin
            model_reset(0);
            model_reset(1);
            m_s1 = 1'b0;
            m_s2 = 1'b0;
            q_a.delete();
            q_b.delete();
            q_a.push_back({2'b00, m_r[0], 5'b00000});
            q_b.push_back({2'b00, m_r[1], 5'b00000});
        end else begin
            rise = m_s1 & ~m_s2;
            q_a.push_back(model_edge(0, run, rise));
            q_b.push_back(model_edge(1, run, rise));
            m_s2 = m_s1;
            m_s1 = step;
        end
    end

    // Monitor: compares DUT outputs against queued predictions mid-cycle.
    initial forever begin
        bit [7:0] e;
        @(negedge main_clk);
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            n_tests++;
            if ({a_c1, a_c2, a_r, a_strb, a_cnt} !== e) begin
                n_fail++;
                $display("FAIL dut_a c1_c2_r_strb_cnt got=%b required=%b at %0t",
                         {a_c1, a_c2, a_r, a_strb, a_cnt}, e, $time);
            end
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            n_tests++;
            if ({b_c1, b_c2, b_r, b_strb, b_cnt} !== e) begin
                n_fail++;
                $display("FAIL dut_b c1_c2_r_strb_cnt got=%b required=%b at %0t",
                         {b_c1, b_c2, b_r, b_strb, b_cnt}, e, $time);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge main_clk);
        #2;
    endtask

    initial begin
        bit found;
        #1 rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        run   = 1'b1;
        tick(140);
        // run dropped during the first P1 of a fresh start
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        tick(1);
        run = 1'b0;
        tick(20);
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if ($urandom_range(7) == 0) run = ~run;
        end
        // asynchronous reset while dut_a is in P2
        run   = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (a_c2 === 1'b1) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL p2_wait got=timeout required=C2 high within 40 cycles");
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({a_c1, a_c2, a_r, a_strb, a_cnt} !== 8'b0010_0000) begin
            n_fail++;
            $display("FAIL async_rst_a got=%b required=00100000", {a_c1, a_c2, a_r, a_strb, a_cnt});
        end
        n_tests++;
        if ({b_c1, b_c2, b_r, b_strb, b_cnt} !== 8'b0010_0000) begin
            n_fail++;
            $display("FAIL async_rst_b got=%b required=00100000", {b_c1, b_c2, b_r, b_strb, b_cnt});
        end
        tick(1);
        rst_n = 1'b1;
        tick(60);
        // two step pulses one cycle apart from IDLE with run low
        run = 1'b0;
        tick(20);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(1);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(20);
        for (int i = 0; i < 300; i++) begin
            tick(1);
            step = 1'($urandom_range(1));
            run  = ($urandom_range(9) == 0);
        end
        run  = 1'b0;
        step = 1'b0;
        tick(12);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
